gcd_controller: RTL and testbench
=================================

GCD_CONTROLLER -- requirements
Module: gcd_controller

Interface
REQ-001 Parameter: MAX_ITER, default 255, maximum subtract iterations before the error state (1..255).
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 start  input  1  request a new GCD; sampled only in IDLE.
REQ-005 ack  input  1  consumer acknowledge of done or error.
REQ-006 a_zero  input  1  datapath flag: register A == 0.
REQ-007 b_zero  input  1  datapath flag: register B == 0.
REQ-008 zero_flag  input  1  datapath compare flag: A - B == 0.
REQ-009 neg_flag  input  1  datapath compare flag: A - B < 0.
REQ-010 load_ab  output  1  load operand inputs into A and B.
REQ-011 wr_a  output  1  write A - B into A.
REQ-012 wr_b  output  1  write B - A into B.
REQ-013 result_sel  output  1  result source: 0 = A, 1 = B.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  result valid.
REQ-016 error  output  1  iteration limit hit.
REQ-017 iter_count  output  8  subtract iterations in the current or last run.

Function
REQ-018 States: IDLE, LOAD, COMPARE, SUB_A, SUB_B, DONE, ERR.
REQ-019 load_ab, wr_a, wr_b, busy, done and error are Moore decodes of the state register only; they never depend combinationally on inputs.
REQ-020 IDLE: start=1 -> LOAD; otherwise stay in IDLE.
REQ-021 LOAD: load_ab=1; iter_count cleared to 0; next state COMPARE unconditionally.
REQ-022 COMPARE applies this priority, first match wins:
- a_zero -> DONE, result_sel<=1
- b_zero -> DONE, result_sel<=0
- zero_flag -> DONE, result_sel<=0
- iter_count == MAX_ITER -> ERR
- neg_flag -> SUB_B
- else -> SUB_A
REQ-023 SUB_A: wr_a=1 for exactly one cycle; iter_count += 1; next state COMPARE.
REQ-024 SUB_B: wr_b=1 for exactly one cycle; iter_count += 1; next state COMPARE.
REQ-025 iter_count never wraps; REQ-022 guarantees at most MAX_ITER increments.
REQ-026 DONE: done=1, held until ack=1, then next state IDLE.
REQ-027 ERR: error=1, held until ack=1, then next state IDLE.
REQ-028 In DONE and ERR, result_sel and iter_count hold their values and stay valid in IDLE until the next LOAD.
REQ-029 start asserted in any state other than IDLE is ignored and not queued.
REQ-030 start and ack both high in DONE or ERR: ack wins, next state IDLE, start is not captured.
REQ-031 ack asserted in a state other than DONE or ERR has no effect.
REQ-032 load_ab, wr_a and wr_b are mutually exclusive; done and error are mutually exclusive.
REQ-033 Latency from start sampled to done is 2 + 2*N + 1 cycles, where N is the number of iterations.

Reset
REQ-034 rst=1 at any clock edge forces IDLE, overriding all other inputs, including mid-operation and in DONE or ERR.
REQ-035 Values after reset: iter_count=0, result_sel=0, load_ab=0, wr_a=0, wr_b=0, busy=0, done=0, error=0.
REQ-036 The cycle after rst deasserts, the block is in IDLE and accepts start.

Verification
REQ-037 GCD(12,8), bench models the datapath:
- start at c0 -> LOAD c1, COMPARE c2, SUB_A c3, COMPARE c4, SUB_B c5, COMPARE c6, DONE c7
- at DONE: iter_count=2, result_sel=0
REQ-038 Operands A=0, B=9, so a_zero=1 in the first COMPARE -> DONE with result_sel=1, iter_count=0, no wr_a/wr_b pulse.
REQ-039 MAX_ITER=3, flags forced to neg_flag=0, zero_flag=0 -> three SUB_A visits, then ERR with error=1, iter_count=3; ack -> IDLE next cycle.
REQ-040 In DONE, assert start and ack together -> IDLE, LOAD is not entered; start pulsed while in SUB_A -> ignored.
REQ-041 rst pulsed in SUB_B mid-run -> next cycle IDLE with all outputs at reset values; a following start runs normally.

Source files
------------

// File: rtl/gcd_controller.sv
// gcd_controller: control FSM for a subtract-based GCD datapath.
// The datapath owns registers A and B and reports zero/sign flags; this block
// sequences load, compare and subtract steps, counts subtract iterations and
// aborts into an error state once MAX_ITER iterations have been spent.
//
// Handshake: start is a request that is only accepted while busy=0 (IDLE);
// requests at any other time are dropped, not queued. done/error act as
// valid and stay high until ack is seen; ack outside DONE/ERR is ignored,
// and ack wins over a simultaneous start in DONE/ERR.
module gcd_controller #(
  parameter int unsigned MAX_ITER = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       ack,
  input  logic       a_zero,
  input  logic       b_zero,
  input  logic       zero_flag,
  input  logic       neg_flag,
  output logic       load_ab,
  output logic       wr_a,
  output logic       wr_b,
  output logic       result_sel,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] iter_count,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPARE = 3'd2,
    S_SUB_A   = 3'd3,
    S_SUB_B   = 3'd4,
    S_DONE    = 3'd5,
    S_ERR     = 3'd6
  } state_t;

  localparam logic [7:0] MaxIter = 8'(MAX_ITER);

  state_t     state_q, state_d;
  logic [7:0] iter_q, iter_d;
  logic       rsel_q, rsel_d;

  // State, iteration counter and result-select registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      iter_q  <= 8'd0;
      rsel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      rsel_q  <= rsel_d;
    end
  end

  // Next-state logic; counter and result select hold unless a state updates them.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    rsel_d  = rsel_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        iter_d  = 8'd0;
        state_d = S_COMPARE;
      end
      S_COMPARE: begin
        // Zero checks come first so a zero operand never burns an iteration.
        if (a_zero) begin
          state_d = S_DONE;
          rsel_d  = 1'b1;
        end else if (b_zero) begin
          state_d = S_DONE;
          rsel_d  = 1'b0;
        end else if (zero_flag) begin
          state_d = S_DONE;
          rsel_d  = 1'b0;
        end else if (iter_q == MaxIter) begin
          state_d = S_ERR;
        end else if (neg_flag) begin
          state_d = S_SUB_B;
        end else begin
          state_d = S_SUB_A;
        end
      end
      S_SUB_A: begin
        // The MAX_ITER check in COMPARE bounds the count, so it cannot wrap.
        iter_d  = iter_q + 8'd1;
        state_d = S_COMPARE;
      end
      S_SUB_B: begin
        iter_d  = iter_q + 8'd1;
        state_d = S_COMPARE;
      end
      S_DONE: begin
        if (ack) state_d = S_IDLE;
      end
      S_ERR: begin
        if (ack) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore output decodes: functions of the state register only.
  always_comb begin
    load_ab = (state_q == S_LOAD);
    wr_a    = (state_q == S_SUB_A);
    wr_b    = (state_q == S_SUB_B);
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    error   = (state_q == S_ERR);
  end

  assign result_sel = rsel_q;
  assign iter_count = iter_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_gcd_controller.sv
// tb_gcd_controller: randomized and directed stimulus for gcd_controller with
// a behavioural datapath, a reference GCD model and a queue-based scoreboard.
module tb_gcd_controller;

  localparam int EW = 66; // {err, sel, iter[8], n_a[8], n_b[8], gcd[8], done_cycle[32]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, ack;
  logic a_zero, b_zero, zero_flag, neg_flag;
  logic load_ab, wr_a, wr_b, result_sel, busy, done, error;
  logic [7:0] iter_count;
  logic [2:0] state_dbg;

  // second instance with a small iteration limit and frozen flags
  logic start3, ack3;
  logic flag_lo = 1'b0;
  logic load3, wr_a3, wr_b3, rsel3, busy3, done3, error3;
  logic [7:0] iter3;
  logic [2:0] state3;

  logic [7:0] reg_a, reg_b, op_a, op_b;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];

  gcd_controller u_dut (
    .clk(clk), .rst(rst), .start(start), .ack(ack),
    .a_zero(a_zero), .b_zero(b_zero), .zero_flag(zero_flag), .neg_flag(neg_flag),
    .load_ab(load_ab), .wr_a(wr_a), .wr_b(wr_b), .result_sel(result_sel),
    .busy(busy), .done(done), .error(error), .iter_count(iter_count),
    .state_o(state_dbg)
  );

  gcd_controller #(.MAX_ITER(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .ack(ack3),
    .a_zero(flag_lo), .b_zero(flag_lo), .zero_flag(flag_lo), .neg_flag(flag_lo),
    .load_ab(load3), .wr_a(wr_a3), .wr_b(wr_b3), .result_sel(rsel3),
    .busy(busy3), .done(done3), .error(error3), .iter_count(iter3),
    .state_o(state3)
  );

  // behavioural datapath: A/B registers driven by the controller strobes
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load_ab) begin
      reg_a <= op_a;
      reg_b <= op_b;
    end else if (wr_a) begin
      reg_a <= reg_a - reg_b;
    end else if (wr_b) begin
      reg_b <= reg_b - reg_a;
    end
  end

  assign a_zero    = (reg_a == 8'd0);
  assign b_zero    = (reg_b == 8'd0);
  assign zero_flag = (reg_a == reg_b);
  assign neg_flag  = (reg_a < reg_b);

  // ---------------- reference model ----------------
  function automatic int gcd_ref(input int a, input int b);
    int x = a;
    int y = b;
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic logic [EW-1:0] model(input int a, input int b, input int max_iter,
                                          input int start_cyc);
    int x = a;
    int y = b;
    int n = 0;
    int na = 0;
    int nb = 0;
    bit err = 1'b0;
    bit sel = 1'b0;
    int g;
    int done_cyc;
    while (1) begin
      if (x == 0) begin sel = 1'b1; break; end
      if (y == 0) break;
      if (x == y) break;
      if (n == max_iter) begin err = 1'b1; break; end
      if (x < y) begin y = y - x; nb++; end
      else begin x = x - y; na++; end
      n++;
    end
    g = gcd_ref(a, b);
    done_cyc = start_cyc + 2 + 2 * n + 1;
    return {err, sel, 8'(n), 8'(na), 8'(nb), 8'(g), 32'(done_cyc)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int sig(input logic ld, input logic wa, input logic wb,
                             input logic dn, input logic er, input logic bz);
    if (ld) return 1;
    if (wa) return 2;
    if (wb) return 3;
    if (dn) return 4;
    if (er) return 5;
    if (bz) return 0;
    return 9;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  int  cnt_a, cnt_b;
  bit  seen, prev_wa, prev_wb, prev_ld;
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst !== 1'b0) begin
      seen = 1'b0; cnt_a = 0; cnt_b = 0;
      prev_wa = 1'b0; prev_wb = 1'b0; prev_ld = 1'b0;
    end else begin
      check("strobe_excl", $countones({load_ab, wr_a, wr_b}) <= 1, 1);
      check("done_err_excl", done && error, 0);
      check("strobe_single", (wr_a && prev_wa) || (wr_b && prev_wb) || (load_ab && prev_ld), 0);
      if (load_ab) begin cnt_a = 0; cnt_b = 0; end
      if (wr_a) cnt_a++;
      if (wr_b) cnt_b++;
      if ((done || error) && !seen) begin
        seen = 1'b1;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got done/error with 0 pending, expected none");
        end else begin
          e = exp_q.pop_front();
          check("error_flag", error, e[65]);
          check("done_flag", done, !e[65]);
          check("iter_count", iter_count, e[63:56]);
          check("wr_a_pulses", cnt_a, e[55:48]);
          check("wr_b_pulses", cnt_b, e[47:40]);
          check("done_cycle", cyc, e[31:0]);
          if (!e[65]) begin
            check("result_sel", result_sel, e[64]);
            check("gcd_value", result_sel ? reg_b : reg_a, e[39:32]);
          end
        end
      end else if (!(done || error)) begin
        seen = 1'b0;
      end
      prev_wa = wr_a; prev_wb = wr_b; prev_ld = load_ab;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int w = 0;
    while (busy !== 1'b0 && w < 50) begin tick(); w++; end
    if (w >= 50) check("idle_timeout", 1, 0);
  endtask

  task automatic run_gcd(input logic [7:0] a, input logic [7:0] b, input bit noise,
                         input bit poke_sub, input bit ack_start);
    int w = 0;
    wait_idle();
    op_a = a; op_b = b; start = 1'b1;
    exp_q.push_back(model(a, b, 255, cyc));
    tick();
    start = 1'b0;
    while (!(done || error) && w < 2000) begin
      ack   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      start = poke_sub && wr_a;
      tick();
      w++;
    end
    ack = 1'b0; start = 1'b0;
    if (w >= 2000) check("done_timeout", 1, 0);
    repeat ($urandom_range(0, 3)) tick();
    check("done_held", done || error, 1);
    ack = 1'b1;
    if (ack_start) start = 1'b1;
    tick();
    ack = 1'b0; start = 1'b0;
    check("idle_after_ack", busy, 0);
    check("no_load_after_ack", load_ab, 0);
    tick();
    check("still_idle", busy, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_strobes"}, {load_ab, wr_a, wr_b}, 0);
    check({tag, "_iter"}, iter_count, 0);
    check({tag, "_rsel"}, result_sel, 0);
  endtask

  // ---------------- main sequence ----------------
  int exp_trace[7] = '{1, 0, 2, 0, 3, 0, 4};
  int exp_trace3[9] = '{1, 0, 2, 0, 2, 0, 2, 0, 5};

  initial begin
    int w;
    rst = 1'b1; start = 1'b0; ack = 1'b0; start3 = 1'b0; ack3 = 1'b0;
    op_a = 8'd0; op_b = 8'd0;
    repeat (3) tick();
    check_reset_values("reset");
    check("reset3_busy", busy3, 0);
    rst = 1'b0;

    // GCD(12,8): cycle-by-cycle state trace
    op_a = 8'd12; op_b = 8'd8; start = 1'b1;
    exp_q.push_back(model(12, 8, 255, cyc));
    for (int i = 0; i < 7; i++) begin
      tick();
      start = 1'b0;
      check($sformatf("trace_12_8_c%0d", i + 1),
            sig(load_ab, wr_a, wr_b, done, error, busy), exp_trace[i]);
    end
    check("gcd12_8_iter", iter_count, 2);
    check("gcd12_8_rsel", result_sel, 0);
    ack = 1'b1; tick(); ack = 1'b0;
    check("gcd12_8_idle", busy, 0);
    check("gcd12_8_iter_hold", iter_count, 2);

    // zero and equal operands, longest run, ack+start and start-in-SUB_A cases
    run_gcd(8'd0, 8'd9, 1'b0, 1'b0, 1'b0);
    run_gcd(8'd9, 8'd0, 1'b0, 1'b0, 1'b0);
    run_gcd(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    run_gcd(8'd7, 8'd7, 1'b1, 1'b0, 1'b0);
    run_gcd(8'd255, 8'd1, 1'b0, 1'b0, 1'b0);
    run_gcd(8'd1, 8'd255, 1'b1, 1'b0, 1'b0);
    run_gcd(8'd12, 8'd8, 1'b0, 1'b0, 1'b1);
    run_gcd(8'd30, 8'd4, 1'b0, 1'b1, 1'b0);

    // reset in SUB_B mid-run, then a normal run
    wait_idle();
    op_a = 8'd12; op_b = 8'd8; start = 1'b1;
    tick();
    start = 1'b0;
    w = 0;
    while (!wr_b && w < 50) begin tick(); w++; end
    if (w >= 50) check("sub_b_timeout", 1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_values("midrst");
    run_gcd(8'd12, 8'd8, 1'b0, 1'b0, 1'b0);

    // randomized runs
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      if (i % 3 == 0) begin
        ra = 8'($urandom_range(0, 15));
        rb = 8'($urandom_range(0, 15));
      end else begin
        ra = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(1, 255));
      end
      run_gcd(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    end

    // iteration limit: MAX_ITER=3 with flags frozen low
    start3 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      start3 = 1'b0;
      check($sformatf("trace_err_c%0d", i + 1),
            sig(load3, wr_a3, wr_b3, done3, error3, busy3), exp_trace3[i]);
    end
    check("err_iter", iter3, 3);
    check("err_flag", error3, 1);
    check("err_no_done", done3, 0);
    tick();
    check("err_held", error3, 1);
    ack3 = 1'b1; tick(); ack3 = 1'b0;
    check("err_ack_idle", busy3, 0);
    check("err_cleared", error3, 0);
    check("err_iter_hold", iter3, 3);

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
